// File: rtl/tdm_pkg.sv
// ============================================================================
// tdm_pkg
// Shared types and constants for the 4-lane TDM receive demultiplexer.
//
// Optional build macro: TDM_PARITY_EN
//   When defined, each slot word is followed by one even-parity bit, so a
//   slot is WIDTH+1 link bits long instead of WIDTH.
//
// Contents:
//   tdm_state_t  - framing state (HUNT / LOCKED)
//   NUM_LANES    - number of slots / output lanes per frame
//   slot_idx_t   - slot index type (0..3)
//   slot_bits()  - link bits per slot for a given word width
// ============================================================================
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    localparam int NUM_LANES = 4;

    typedef logic [1:0] slot_idx_t;

    function automatic int slot_bits(input int width);
`ifdef TDM_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// ============================================================================
// tdm_demux4_if
// Bundles the serial link input and the parallel frame output of tdm_demux4.
//
// Optional build macro: TDM_PARITY_EN (adds parity_err)
//
// Signals:
//   serial_in   - link data bit
//   in_valid    - qualifies serial_in / frame_sync
//   frame_sync  - marks first bit of slot 0
//   line1..4_out- words of the last complete frame
//   frame_valid - one-cycle pulse when line outputs update
//   cntrl_out   - slot index being received
//   locked      - receiver is frame-locked
//   sync_err    - one-cycle pulse on framing violation
//   parity_err  - per-lane parity failure of last frame (TDM_PARITY_EN only)
//
// Modports:
//   master - link side / consumer (drives serial inputs, reads outputs)
//   slave  - the demultiplexer itself
// ============================================================================
interface tdm_demux4_if #(
    parameter int WIDTH = 8
);
    logic             serial_in;
    logic             in_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] line1_out;
    logic [WIDTH-1:0] line2_out;
    logic [WIDTH-1:0] line3_out;
    logic [WIDTH-1:0] line4_out;
    logic             frame_valid;
    logic [1:0]       cntrl_out;
    logic             locked;
    logic             sync_err;
`ifdef TDM_PARITY_EN
    logic [3:0]       parity_err;
`endif

    modport master (
`ifdef TDM_PARITY_EN
        input  parity_err,
`endif
        output serial_in, in_valid, frame_sync,
        input  line1_out, line2_out, line3_out, line4_out,
        input  frame_valid, cntrl_out, locked, sync_err
    );

    modport slave (
`ifdef TDM_PARITY_EN
        output parity_err,
`endif
        input  serial_in, in_valid, frame_sync,
        output line1_out, line2_out, line3_out, line4_out,
        output frame_valid, cntrl_out, locked, sync_err
    );

endinterface

// File: rtl/tdm_slot_shifter.sv
// ============================================================================
// tdm_slot_shifter
// LSB-first shift register and bit counter for one TDM slot. Signals
// word_done combinationally on the bit that completes a slot, together with
// the completed word, so the parent can capture it in the same cycle.
//
// Optional build macro: TDM_PARITY_EN
//   Slot is WIDTH data bits + 1 even-parity bit; the parity bit is not
//   shifted into the word and parity_bad flags a failed check on word_done.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   serial_in      - link data bit
//   shift_en       - consume serial_in this cycle
//   restart        - consumed bit is bit 0 of a new slot (forces counter)
//   word_done      - this bit completes the slot
//   word           - completed word (valid with word_done)
//   at_slot_start  - next consumed bit would be bit 0 of a slot
//   parity_bad     - parity check failed (TDM_PARITY_EN only)
// ============================================================================
module tdm_slot_shifter
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             restart,
`ifdef TDM_PARITY_EN
    output logic             parity_bad,
`endif
    output logic             word_done,
    output logic [WIDTH-1:0] word,
    output logic             at_slot_start
);

    localparam int SLOT_BITS = slot_bits(WIDTH);
    localparam int CNT_W     = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_BITS - 1);

    logic [WIDTH-1:0] sreg_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [WIDTH-1:0] shifted;
    logic             is_last;

    assign shifted       = {serial_in, sreg_reg[WIDTH-1:1]};
    assign is_last       = (bit_cnt_reg == LAST_BIT);
    assign at_slot_start = (bit_cnt_reg == '0);
    // A restart bit is always bit 0, so it can never complete a slot.
    assign word_done     = shift_en & ~restart & is_last;

`ifdef TDM_PARITY_EN
    // On the parity bit the register already holds the full word.
    assign word       = sreg_reg;
    assign parity_bad = ^{sreg_reg, serial_in};
`else
    assign word       = shifted;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_reg    <= '0;
            bit_cnt_reg <= '0;
        end else if (shift_en) begin
            if (restart) begin
                sreg_reg    <= shifted;
                bit_cnt_reg <= CNT_W'(1);
            end else begin
                bit_cnt_reg <= is_last ? '0 : bit_cnt_reg + CNT_W'(1);
`ifdef TDM_PARITY_EN
                if (!is_last) begin
                    sreg_reg <= shifted;
                end
`else
                sreg_reg <= shifted;
`endif
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// ============================================================================
// tdm_demux4
// Receive end of the 4-line TDM link. Locks onto frame_sync, de-serialises
// four LSB-first slot words per frame and presents them together on
// line1..4_out with a one-cycle frame_valid pulse one clock after the last
// bit of slot 3. Framing violations raise a one-cycle sync_err pulse.
//
// Optional build macro: TDM_PARITY_EN
//   Adds a per-slot even-parity bit and the parity_err[3:0] output, updated
//   with frame_valid. Frames are delivered even when parity fails.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - tdm_demux4_if.slave (serial input side and frame output side)
// ============================================================================
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux4_if.slave   bus
);

    tdm_state_t       state_reg;
    slot_idx_t        cntrl_reg;
    logic [WIDTH-1:0] stage_reg [NUM_LANES-1];
    logic [WIDTH-1:0] line_reg  [NUM_LANES];
    logic             frame_valid_reg;
    logic             sync_err_reg;
    logic             locked_reg;

    logic             shift_en;
    logic             restart;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             at_slot_start;
    logic             at_frame_start;
    logic             lost_sync;
    logic             resync;
    logic             frame_done;

`ifdef TDM_PARITY_EN
    logic                   parity_bad;
    logic [NUM_LANES-2:0]   par_stage_reg;
    logic [NUM_LANES-1:0]   parity_err_reg;
`endif

    tdm_slot_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk           (clk),
        .rst_n         (rst_n),
        .serial_in     (bus.serial_in),
        .shift_en      (shift_en),
        .restart       (restart),
`ifdef TDM_PARITY_EN
        .parity_bad    (parity_bad),
`endif
        .word_done     (word_done),
        .word          (word),
        .at_slot_start (at_slot_start)
    );

    // Framing decisions for the current qualified bit.
    always_comb begin
        at_frame_start = (cntrl_reg == 2'd0) && at_slot_start;
        lost_sync      = 1'b0;
        resync         = 1'b0;
        shift_en       = 1'b0;
        restart        = 1'b0;
        if (bus.in_valid) begin
            if (state_reg == HUNT) begin
                shift_en = bus.frame_sync;
                restart  = bus.frame_sync;
            end else begin
                // Missing sync at a frame boundary drops the bit and lock;
                // sync anywhere else restarts the frame on this bit.
                lost_sync = at_frame_start & ~bus.frame_sync;
                resync    = ~at_frame_start & bus.frame_sync;
                shift_en  = ~lost_sync;
                restart   = resync;
            end
        end
    end

    assign frame_done = word_done && (cntrl_reg == 2'd3);

    // Framing FSM, slot counter and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= HUNT;
            cntrl_reg       <= 2'd0;
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
            locked_reg      <= 1'b0;
        end else begin
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
            if (bus.in_valid) begin
                case (state_reg)
                    HUNT: begin
                        if (bus.frame_sync) begin
                            state_reg  <= LOCKED;
                            locked_reg <= 1'b1;
                            cntrl_reg  <= 2'd0;
                        end
                    end
                    LOCKED: begin
                        if (lost_sync) begin
                            sync_err_reg <= 1'b1;
                            state_reg    <= HUNT;
                            locked_reg   <= 1'b0;
                            cntrl_reg    <= 2'd0;
                        end else if (resync) begin
                            sync_err_reg <= 1'b1;
                            cntrl_reg    <= 2'd0;
                        end else if (word_done) begin
                            cntrl_reg <= cntrl_reg + 2'd1;
                            if (frame_done) begin
                                frame_valid_reg <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg  <= HUNT;
                        locked_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Staging for slots 0..2 and the frame output registers. Slot 3 is taken
    // straight from the shifter so all lanes update in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES - 1; i++) begin
                stage_reg[i] <= '0;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                line_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES - 1; i++) begin
                if (word_done && (cntrl_reg == slot_idx_t'(i))) begin
                    stage_reg[i] <= word;
                end
            end
            if (frame_done) begin
                for (int i = 0; i < NUM_LANES - 1; i++) begin
                    line_reg[i] <= stage_reg[i];
                end
                line_reg[NUM_LANES-1] <= word;
            end
        end
    end

`ifdef TDM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_stage_reg  <= '0;
            parity_err_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES - 1; i++) begin
                if (word_done && (cntrl_reg == slot_idx_t'(i))) begin
                    par_stage_reg[i] <= parity_bad;
                end
            end
            if (frame_done) begin
                parity_err_reg <= {parity_bad, par_stage_reg};
            end
        end
    end

    assign bus.parity_err = parity_err_reg;
`endif

    assign bus.line1_out   = line_reg[0];
    assign bus.line2_out   = line_reg[1];
    assign bus.line3_out   = line_reg[2];
    assign bus.line4_out   = line_reg[3];
    assign bus.frame_valid = frame_valid_reg;
    assign bus.cntrl_out   = cntrl_reg;
    assign bus.locked      = locked_reg;
    assign bus.sync_err    = sync_err_reg;

endmodule
